// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: state encoding, widths and the reset instruction.
// Latency: none; constants and types only.
// Backpressure: not applicable.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bus: ROM address/enable/data plus the IF/ID valid/ready output channel.
// Latency: none; wiring only.
// Backpressure: out_ready from decode gates the fetch side's loads.
interface instr_fetch_unit_if;
  import mips_pkg::*;

  logic [ADDR_W-1:0]  rom_address;
  logic               rom_read_en;
  logic               rom_ce;
  logic [INSTR_W-1:0] rom_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_plus4;

  modport master (
    output rom_address, rom_read_en, rom_ce,
    input  rom_data,
    output out_valid, out_instr, out_pc, out_pc_plus4,
    input  out_ready
  );

  modport slave (
    input  rom_address, rom_read_en, rom_ce,
    output rom_data,
    input  out_valid, out_instr, out_pc, out_pc_plus4,
    output out_ready
  );

endinterface

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register holding one instruction with its pc and pc+4.
// Latency: 1 edge from load to valid output.
// Backpressure: contents hold while valid && !ready; flush drops the entry.
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic               ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4
);

  // Flush beats load; an accepted entry with no replacement empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= NOP;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= in_instr;
      pc       <= in_pc;
      pc_plus4 <= in_pc + 32'd4;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, start/stop/redirect FSM, ROM drive and sticky fault capture.
// Latency: 2 edges from start or redirect to the first valid instruction; 1/cycle streaming.
// Backpressure: no ROM read and no PC advance while out_valid && !out_ready.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned       ROM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc,
  instr_fetch_unit_if.master bus
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] fault_pc_n;
  logic              load_ok, pc_bad, load, flush;
  logic              reg_valid;
  logic [INSTR_W-1:0] reg_instr;
  logic [ADDR_W-1:0] reg_pc, reg_pc_plus4;

  assign load_ok = !reg_valid || bus.out_ready;
  assign pc_bad  = ({2'b00, pc[31:2]} >= ROM_WORDS);

  assign bus.rom_address  = {2'b00, pc[31:2]};
  assign bus.rom_ce       = (state == S_FETCH);
  assign bus.rom_read_en  = bus.rom_ce && load_ok;
  assign bus.out_valid    = reg_valid;
  assign bus.out_instr    = reg_instr;
  assign bus.out_pc       = reg_pc;
  assign bus.out_pc_plus4 = reg_pc_plus4;
  assign fault            = (state == S_FAULT);

  // State, PC and fault address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fault_pc <= fault_pc_n;
    end
  end

  // Next state and PC: redirect, then bad-PC fault, then load; stop overrides the target state.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    fault_pc_n = fault_pc;
    load       = 1'b0;
    flush      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            state_n    = S_FAULT;
            fault_pc_n = redirect_pc;
          end else begin
            pc_n = redirect_pc;
          end
        end else if (load_ok && pc_bad) begin
          flush      = 1'b1;
          state_n    = S_FAULT;
          fault_pc_n = pc;
        end else if (load_ok) begin
          load = 1'b1;
          pc_n = pc + 32'd4;
        end
        if (stop && state_n != S_FAULT) state_n = S_IDLE;
      end
      S_FAULT: begin
        flush = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .flush    (flush),
    .ready    (bus.out_ready),
    .in_instr (bus.rom_data),
    .in_pc    (pc),
    .valid    (reg_valid),
    .instr    (reg_instr),
    .pc       (reg_pc),
    .pc_plus4 (reg_pc_plus4)
  );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of rom_using_case. Holds the program counter and drives the ROM's address, read_en and ce. Captures the ROM's combinational data output into a registered IF/ID output, which uses a valid/ready handshake to the decode stage. Supports start/stop control, branch/jump redirect, and a sticky fault state for bad fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
ROM_WORDS, 256, number of 32-bit words in the ROM; word index >= ROM_WORDS is out of range

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  IDLE -> FETCH request
stop  input  1  FETCH -> IDLE request
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  byte-address target of redirect
rom_address  output  32  word index to ROM = {2'b00, pc[31:2]}
rom_read_en  output  1  ROM read enable
rom_ce  output  1  ROM chip enable
rom_data  input  32  ROM instruction word, combinational from rom_address
out_valid  output  1  IF/ID register holds a valid instruction
out_ready  input  1  decode accepts the instruction this cycle
out_instr  output  32  fetched instruction
out_pc  output  32  byte address of out_instr
out_pc_plus4  output  32  out_pc + 4, mod 2^32
fault  output  1  sticky fetch fault
fault_pc  output  32  PC that caused the fault

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, fault=0, fault_pc=0. rom_ce and rom_read_en are 0.
- Reset mid-operation discards the IF/ID contents immediately.
- rom_address = {2'b00, pc[31:2]} in every state.
- rom_ce = (state==FETCH). rom_read_en = rom_ce && load_ok.
- load_ok = !out_valid || out_ready.
- States: IDLE, FETCH, FAULT. State is one-hot or 2-bit encoded.
- IDLE: rom_ce=0, pc holds, and out_valid may still drain by handshake. start=1 -> FETCH on the next edge.
- FETCH, priority order at each edge:
  1. Redirect:
     - Misaligned target (redirect_pc[1:0]!=0) -> FAULT, fault_pc=redirect_pc.
     - Otherwise pc <= redirect_pc and out_valid <= 0, flushing the wrong-path instruction.
     - If out_ready=1 in the same cycle, the current instruction is still consumed; only its successor is squashed.
  2. Bad current pc: if pc[31:2] >= ROM_WORDS and load_ok -> FAULT, fault_pc=pc, out_valid <= 0.
  3. Normal load (load_ok): out_instr <= rom_data, out_pc <= pc, out_pc_plus4 <= pc+4, out_valid <= 1, pc <= pc+4 (32-bit wrap).
  4. Stall (!load_ok): all registers hold, and out_instr/out_pc stay stable while out_valid=1.
- stop=1 in FETCH -> IDLE on the next edge.
  - A load in the same cycle still completes.
  - A redirect in the same cycle is still applied to pc.
- start and stop asserted together in IDLE: start wins. In FETCH, stop wins.
- FAULT: rom_ce=0, out_valid=0, fault=1, pc frozen. Only rst_n exits FAULT; start, stop and redirect are ignored.
- Latency:
  - Start to first out_valid: 2 edges (IDLE->FETCH, then load).
  - Redirect to out_valid with out_pc=target: 2 edges.
  - Sustained throughput: 1 instruction per cycle while out_ready=1.

Decomposition:
- Shared package mips_pkg: fetch state encoding (S_IDLE, S_FETCH, S_FAULT), INSTR_W=32, ADDR_W=32, NOP=32'h0000_0000.
- One natural sub-module: if_id_reg, the output register with valid/ready hold and flush input. The PC/FSM logic stays in instr_fetch_unit.

Test Plan:
- Reset release with RESET_PC=0, start=1, out_ready=1, ROM stubbed with rom_data=addr*3 → out_pc 0,4,8 with out_instr 0,3,6 on consecutive cycles, and out_valid stays 1.
- Backpressure: out_ready=0 for 3 cycles while out_pc=8 → out_instr, out_pc and pc unchanged, rom_read_en=0. After release, the next beat is out_pc=12.
- Redirect to 32'h40 while out_pc=4 is valid and out_ready=1 → PC 4 is consumed, the next cycle has out_valid=0, and the cycle after has out_pc=32'h40.
- Redirect to 32'h42 → fault=1, fault_pc=32'h42, out_valid=0, rom_ce=0. Later redirect_valid and start are ignored until rst_n=0.
- Sequential run with ROM_WORDS=4 from pc=0 → out_pc 0..12 delivered, then fault=1 with fault_pc=16.
- stop during streaming, then rst_n low mid-FETCH → IDLE holds pc and drains out_valid via out_ready. The async reset clears out_valid and pc=RESET_PC without waiting for a clock edge.
